// File: rtl/down_counter_ld.sv
// Loadable down-counter with IDLE/RUN/DONE control and a valid/ready load handshake.
// Optional auto-reload of the last accepted load value: define DOWNCNT_AUTORELOAD_EN.
module down_counter_ld #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    logic             w_load_fire;

    // clr outranks a load, so a load offered together with clr is not accepted
    assign w_load_fire = load_valid && (r_state == S_IDLE) && !clr;

`ifdef DOWNCNT_AUTORELOAD_EN
    logic [WIDTH-1:0] r_reload;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reload <= '0;
        end else if (w_load_fire) begin
            r_reload <= load_value;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        if (clr) begin
            w_state_next = S_IDLE;
            w_count_next = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_load_fire) begin
                        w_count_next = load_value;
                        w_state_next = (load_value == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (en) begin
                        // <= also covers an (unreachable) zero count so it can never wrap
                        if (r_count <= ONE) begin
                            w_count_next = '0;
                            w_state_next = S_DONE;
                        end else begin
                            w_count_next = r_count - ONE;
                        end
                    end
                end
                S_DONE: begin
`ifdef DOWNCNT_AUTORELOAD_EN
                    if (r_reload != '0) begin
                        w_count_next = r_reload;
                        w_state_next = S_RUN;
                    end else begin
                        w_state_next = S_IDLE;
                    end
`else
                    w_state_next = S_IDLE;
`endif
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_count_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    assign load_ready = (r_state == S_IDLE);
    assign busy       = (r_state == S_RUN) || (r_state == S_DONE);
    assign done       = (r_state == S_DONE);
    assign count      = r_count;

endmodule

// File: tb/tb_down_counter_ld.sv
// Self-checking bench for down_counter_ld: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a behavioural model.
module tb_down_counter_ld;

`ifdef DOWNCNT_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       clr;
    logic       load_valid;
    logic [7:0] load_value;
    logic       load_ready;
    logic [7:0] count;
    logic       busy;
    logic       done;

    int total;
    int bad;

    down_counter_ld #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .clr        (clr),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       en;
        bit       clr;
        bit       lv;
        bit [7:0] val;
        bit [7:0] ecount;
        bit       ebusy;
        bit       edone;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit e, input bit c, input bit lv, input int v,
                       input int ec, input bit eb, input bit ed);
        vec_t r;
        r.en = e; r.clr = c; r.lv = lv; r.val = 8'(v);
        r.ecount = 8'(ec); r.ebusy = eb; r.edone = ed;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int ec, input bit eb, input bit ed);
        chk({tag, " count"}, int'(count), ec);
        chk({tag, " busy"}, int'(busy), int'(eb));
        chk({tag, " done"}, int'(done), int'(ed));
        chk({tag, " load_ready"}, int'(load_ready), int'(!eb));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit e, input bit c, input bit lv, input int v);
        en = e; clr = c; load_valid = lv; load_value = 8'(v);
    endtask

    // behavioural reference state
    int m_count;
    int m_reload;
    bit m_busy;
    bit m_done;

    task automatic model_step(input bit e, input bit c, input bit lv, input int v);
        if (c) begin
            m_count = 0; m_busy = 0; m_done = 0;
        end else if (m_done) begin
            m_done = 0;
            if (AR && m_reload != 0) begin
                m_count = m_reload; m_busy = 1;
            end else begin
                m_busy = 0;
            end
        end else if (m_busy) begin
            if (e) begin
                m_count = m_count - 1;
                if (m_count == 0) m_done = 1;
            end
        end else if (lv) begin
            m_count = v; m_reload = v; m_busy = 1; m_done = (v == 0);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        drive(0, 0, 0, 0);
        reset_n = 1'b0;

        // load 5, en held: 5..0, done once, then idle (clr stops auto-reload)
        add(1, 0, 1, 5, 5, 1, 0);
        add(1, 0, 0, 0, 4, 1, 0);
        add(1, 0, 0, 0, 3, 1, 0);
        add(1, 0, 0, 0, 2, 1, 0);
        add(1, 0, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 0, 1, 1);
        add(1, AR, 0, 0, 0, 0, 0);
        // load 3, en 1,0,0,1,1
        add(0, 0, 1, 3, 3, 1, 0);
        add(1, 0, 0, 0, 2, 1, 0);
        add(0, 0, 0, 0, 2, 1, 0);
        add(0, 0, 0, 0, 2, 1, 0);
        add(1, 0, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 0, 1, 1);
        add(0, AR, 0, 0, 0, 0, 0);
        // load 4, offer 9 while running, clr at 2
        add(1, 0, 1, 4, 4, 1, 0);
        add(1, 0, 1, 9, 3, 1, 0);
        add(1, 0, 1, 9, 2, 1, 0);
        add(1, 1, 1, 9, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        // zero-length load, load offered in DONE ignored
        add(0, 0, 1, 0, 0, 1, 1);
        add(0, 0, 1, 7, 0, 0, 0);
        // clr beats load in IDLE; en alone does nothing in IDLE
        add(0, 1, 1, 5, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        // en low holds RUN
        add(0, 0, 1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 0, 1, 1);
        add(0, AR, 0, 0, 0, 0, 0);

        #12;
        chk_outs("reset", 0, 0, 0);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].clr, vecs[i].lv, int'(vecs[i].val));
            tick();
            $display("vec %0d en=%0d clr=%0d lv=%0d val=%0d -> count=%0d busy=%0d done=%0d ready=%0d",
                     i, vecs[i].en, vecs[i].clr, vecs[i].lv, vecs[i].val, count, busy, done, load_ready);
            chk_outs($sformatf("vec%0d", i), int'(vecs[i].ecount), vecs[i].ebusy, vecs[i].edone);
        end
        drive(0, 0, 0, 0);

        // async reset between edges at count=6, then load 2 on the first edge
        drive(1, 0, 1, 8);
        tick();
        drive(1, 0, 0, 0);
        tick();
        tick();
        chk_outs("pre-reset", 6, 1, 0);
        #2 reset_n = 1'b0;
        #1;
        $display("async reset mid-count -> count=%0d busy=%0d done=%0d", count, busy, done);
        chk_outs("async reset", 0, 0, 0);
        #1 reset_n = 1'b1;
        drive(1, 0, 1, 2);
        tick();
        chk_outs("post-reset load", 2, 1, 0);
        drive(1, 0, 0, 0);
        tick();
        chk_outs("post-reset 1", 1, 1, 0);
        tick();
        chk_outs("post-reset done", 0, 1, 1);
        drive(1, AR, 0, 0);
        tick();
        chk_outs("post-reset idle", 0, 0, 0);

        // full-range count, no wrap
        drive(1, 0, 1, 255);
        tick();
        drive(1, 0, 0, 0);
        chk("load255 count", int'(count), 255);
        for (int k = 1; k <= 255; k++) begin
            tick();
            chk($sformatf("dec255 k%0d count", k), int'(count), 255 - k);
            chk($sformatf("dec255 k%0d done", k), int'(done), int'(k == 255));
        end
        $display("load 255 sequence ended count=%0d done=%0d", count, done);
        drive(1, AR, 0, 0);
        tick();
        chk_outs("after255", 0, 0, 0);

        // load 2: single done, or periodic done with auto-reload
        drive(1, 0, 1, 2);
        tick();
        drive(1, 0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("rep k%0d done", k), int'(done), AR ? int'(k % 3 == 2) : int'(k == 2));
            chk($sformatf("rep k%0d busy", k), int'(busy), AR ? 1 : int'(k <= 2));
        end
        $display("repeat sequence ended count=%0d busy=%0d", count, busy);
        drive(1, 1, 0, 0);
        tick();
        chk_outs("rep clr", 0, 0, 0);

        // randomized traffic vs. model
        drive(0, 0, 0, 0);
        reset_n = 1'b0;
        #3 reset_n = 1'b1;
        m_count = 0; m_reload = 0; m_busy = 0; m_done = 0;
        for (int n = 0; n < 600; n++) begin
            bit e, c, lv;
            int v;
            e  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 19) == 0);
            lv = ($urandom_range(0, 2) == 0);
            v  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
            drive(e, c, lv, v);
            model_step(e, c, lv, v);
            tick();
            $display("rnd %0d en=%0d clr=%0d lv=%0d val=%0d -> count=%0d busy=%0d done=%0d",
                     n, e, c, lv, v, count, busy, done);
            chk_outs($sformatf("rnd%0d", n), m_count, m_busy, m_done);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
